// File: rtl/matmul_stream_ctrl.sv
// Byte-stream sequencer for an N x N systolic multiplier: receives a framed command
// and the A/B matrices over a byte link, runs the array, and streams the result back.
module matmul_stream_ctrl #(
    parameter int N         = 12,
    parameter int ACC_W     = 32,
    parameter int OUT_BYTES = 4,
    parameter int TIMEOUT   = 1_000_000
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   rx_valid,
    input  logic [7:0]             rx_data,
    input  logic                   tx_ready,
    output logic                   tx_valid,
    output logic [7:0]             tx_data,
    output logic [N*N*8-1:0]       mm_a,
    output logic [N*N*8-1:0]       mm_b,
    output logic                   mm_start,
    input  logic [N*N*ACC_W-1:0]   mm_c,
    input  logic                   mm_done,
    output logic                   busy,
    output logic                   err
);

    localparam int NE = N * N;
    localparam int IW = $clog2(NE);
    localparam int BW = (OUT_BYTES > 1) ? $clog2(OUT_BYTES) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int CW = (ACC_W > 16) ? ACC_W : 16;

    typedef enum logic [3:0] {
        IDLE, THR_LO, THR_HI, LOAD_A, LOAD_B, START, WAIT, SEND, CHK
    } state_t;

    state_t              state;
    logic                mode;
    logic [15:0]         thr;
    logic [7:0]          chk;
    logic [IW-1:0]       idx;
    logic [BW-1:0]       bidx;
    logic [TW-1:0]       tcnt;
    logic [NE*ACC_W-1:0] res;

    // Payload byte for element i, byte b: raw slice or binarized threshold compare.
    function automatic logic [7:0] pick(input logic [NE*ACC_W-1:0] c, input logic [IW-1:0] i,
                                        input logic [BW-1:0] b, input logic bin,
                                        input logic [15:0] t);
        logic [ACC_W-1:0] e;
        e = c[int'(i)*ACC_W +: ACC_W];
        if (bin)
            return (CW'(e) >= CW'(t)) ? 8'hFF : 8'h00;
        return e[int'(b)*8 +: 8];
    endfunction

    logic last_byte;
    logic last_elem;
    assign last_byte = mode || (bidx == BW'(OUT_BYTES - 1));
    assign last_elem = (idx == IW'(NE - 1));
    assign busy      = (state != IDLE);

    // NOTE: the result buffer has no reset; it is always overwritten before it is read.
    always_ff @(posedge clk) begin
        if (state == WAIT && mm_done)
            res <= mm_c;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            mode     <= 1'b0;
            thr      <= '0;
            chk      <= '0;
            idx      <= '0;
            bidx     <= '0;
            tcnt     <= '0;
            tx_valid <= 1'b0;
            tx_data  <= '0;
            mm_a     <= '0;
            mm_b     <= '0;
            mm_start <= 1'b0;
            err      <= 1'b0;
        end else begin
            // NOTE: pulse outputs default low each cycle and are only set where they fire.
            err      <= 1'b0;
            mm_start <= 1'b0;
            case (state)
                IDLE: begin
                    if (rx_valid) begin
                        if (rx_data == 8'h00 || rx_data == 8'h01) begin
                            mode  <= rx_data[0];
                            chk   <= '0;
                            idx   <= '0;
                            bidx  <= '0;
                            tcnt  <= '0;
                            state <= rx_data[0] ? THR_LO : LOAD_A;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                THR_LO, THR_HI, LOAD_A, LOAD_B: begin
                    if (rx_valid) begin
                        tcnt <= '0;
                        case (state)
                            THR_LO: begin
                                thr[7:0] <= rx_data;
                                state    <= THR_HI;
                            end
                            THR_HI: begin
                                thr[15:8] <= rx_data;
                                state     <= LOAD_A;
                            end
                            LOAD_A: begin
                                mm_a[int'(idx)*8 +: 8] <= rx_data;
                                idx <= last_elem ? '0 : idx + IW'(1);
                                if (last_elem)
                                    state <= LOAD_B;
                            end
                            default: begin
                                mm_b[int'(idx)*8 +: 8] <= rx_data;
                                idx <= last_elem ? '0 : idx + IW'(1);
                                if (last_elem) begin
                                    state    <= START;
                                    mm_start <= 1'b1;
                                end
                            end
                        endcase
                    end else if (tcnt == TW'(TIMEOUT - 1)) begin
                        err   <= 1'b1;
                        state <= IDLE;
                    end else begin
                        tcnt <= tcnt + TW'(1);
                    end
                end
                START: state <= WAIT;
                WAIT: begin
                    // First byte comes straight from mm_c; res is only valid next cycle.
                    if (mm_done) begin
                        tx_data  <= pick(mm_c, '0, '0, mode, thr);
                        tx_valid <= 1'b1;
                        state    <= SEND;
                    end
                end
                SEND: begin
                    if (tx_valid) begin
                        if (tx_ready) begin
                            tx_valid <= 1'b0;
                            chk      <= chk ^ tx_data;
                            if (last_byte) begin
                                bidx <= '0;
                                if (last_elem)
                                    state <= CHK;
                                else
                                    idx <= idx + IW'(1);
                            end else begin
                                bidx <= bidx + BW'(1);
                            end
                        end
                    end else begin
                        tx_valid <= 1'b1;
                        tx_data  <= pick(res, idx, bidx, mode, thr);
                    end
                end
                CHK: begin
                    if (tx_valid) begin
                        if (tx_ready) begin
                            tx_valid <= 1'b0;
                            state    <= IDLE;
                        end
                    end else begin
                        tx_valid <= 1'b1;
                        tx_data  <= chk;
                    end
                end
                default: state <= IDLE;
            endcase
            if (rx_valid && (state inside {START, WAIT, SEND, CHK}))
                err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_matmul_stream_ctrl.sv
// Directed bench for matmul_stream_ctrl with N=2 and a behavioural 2x2 multiplier
// that answers 10 cycles after mm_start.
module tb_matmul_stream_ctrl;

    localparam int N = 2;
    localparam int ACC_W = 32;

    logic              clk = 1'b0;
    logic              reset;
    logic              rx_valid;
    logic [7:0]        rx_data;
    logic              tx_ready;
    logic              tx_valid;
    logic [7:0]        tx_data;
    logic [N*N*8-1:0]  mm_a;
    logic [N*N*8-1:0]  mm_b;
    logic              mm_start;
    logic [N*N*ACC_W-1:0] mm_c;
    logic              mm_done;
    logic              busy;
    logic              err;

    int errors = 0;
    int checks = 0;
    int err_cnt = 0;
    int mm_cnt;
    int stall_viol;
    int stalls_used;
    logic [7:0] rq[$];

    logic [7:0] a_vals[4]    = '{8'h01, 8'h02, 8'h03, 8'h04};
    logic [7:0] b_vals[4]    = '{8'h05, 8'h06, 8'h07, 8'h08};
    logic [7:0] raw_exp[17]  = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h16, 8'h00, 8'h00, 8'h00,
                                 8'h2B, 8'h00, 8'h00, 8'h00, 8'h32, 8'h00, 8'h00, 8'h00,
                                 8'h1C};
    logic [7:0] bin_exp[5]   = '{8'h00, 8'h00, 8'hFF, 8'hFF, 8'h00};

    matmul_stream_ctrl #(.N(N), .ACC_W(ACC_W), .OUT_BYTES(4), .TIMEOUT(100)) dut (
        .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data),
        .tx_ready(tx_ready), .tx_valid(tx_valid), .tx_data(tx_data),
        .mm_a(mm_a), .mm_b(mm_b), .mm_start(mm_start), .mm_c(mm_c),
        .mm_done(mm_done), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    // Array model: C = A*B, done pulse 10 cycles after start.
    always_comb begin
        mm_c = '0;
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 2; j++)
                mm_c[(i*2+j)*32 +: 32] = 32'(mm_a[(i*2)*8 +: 8]) * 32'(mm_b[j*8 +: 8])
                                       + 32'(mm_a[(i*2+1)*8 +: 8]) * 32'(mm_b[(2+j)*8 +: 8]);
    end

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mm_cnt  <= 0;
            mm_done <= 1'b0;
        end else begin
            mm_done <= 1'b0;
            if (mm_start) begin
                mm_cnt <= 10;
            end else if (mm_cnt != 0) begin
                mm_cnt <= mm_cnt - 1;
                if (mm_cnt == 1)
                    mm_done <= 1'b1;
            end
        end
    end

    always @(posedge clk)
        if (err) err_cnt <= err_cnt + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = b;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic send_frame(input logic bin);
        send_byte({7'b0, bin});
        if (bin) begin
            send_byte(8'h20);
            send_byte(8'h00);
        end
        for (int i = 0; i < 4; i++) send_byte(a_vals[i]);
        for (int i = 0; i < 4; i++) send_byte(b_vals[i]);
    endtask

    // Collect n transferred bytes; optionally stall tx_ready up to 'stall' cycles.
    task automatic get_resp(input int n, input int stall);
        int cycles;
        int left;
        logic hold;
        logic [7:0] hold_data;
        rq.delete();
        cycles = 0;
        left = stall;
        hold = 1'b0;
        hold_data = '0;
        stall_viol = 0;
        while (rq.size() < n && cycles < 2000) begin
            @(negedge clk);
            cycles++;
            if (hold && (tx_valid !== 1'b1 || tx_data !== hold_data))
                stall_viol++;
            if (left > 0 && tx_valid && $urandom_range(0, 3) != 0) begin
                tx_ready = 1'b0;
                left--;
            end else begin
                tx_ready = 1'b1;
            end
            if (tx_valid && tx_ready)
                rq.push_back(tx_data);
            hold = tx_valid && !tx_ready;
            hold_data = tx_data;
        end
        stalls_used = stall - left;
        @(negedge clk);
        tx_ready = 1'b0;
    endtask

    task automatic check_resp(input string tag, input logic bin);
        int n;
        logic [7:0] obs;
        n = bin ? 5 : 17;
        check({tag, " length"}, rq.size(), n);
        for (int i = 0; i < n; i++) begin
            obs = (i < rq.size()) ? rq[i] : 8'hxx;
            check($sformatf("%s byte%0d", tag, i), obs, bin ? bin_exp[i] : raw_exp[i]);
        end
        check({tag, " busy after checksum"}, busy, 1'b0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " tx_valid"}, tx_valid, 1'b0);
        check({tag, " tx_data"}, tx_data, 8'h00);
        check({tag, " mm_start"}, mm_start, 1'b0);
        check({tag, " mm_a"}, mm_a, 32'h0);
        check({tag, " mm_b"}, mm_b, 32'h0);
        check({tag, " busy"}, busy, 1'b0);
        check({tag, " err"}, err, 1'b0);
    endtask

    initial begin
        int e0;
        int cnt;
        int seen_tx;
        reset    = 1'b1;
        rx_valid = 1'b0;
        rx_data  = '0;
        tx_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        reset = 1'b0;

        // Raw mode
        send_frame(1'b0);
        check("mm_a packing", mm_a, 32'h04030201);
        check("mm_b packing", mm_b, 32'h08070605);
        check("mm_start after last B", mm_start, 1'b1);
        check("busy in frame", busy, 1'b1);
        @(negedge clk);
        check("mm_start one cycle", mm_start, 1'b0);
        get_resp(17, 0);
        check_resp("raw", 1'b0);

        // Binarize mode, T = 0x0020
        send_frame(1'b1);
        get_resp(5, 0);
        check_resp("binarize", 1'b1);

        // Bad command
        e0 = err_cnt;
        seen_tx = 0;
        send_byte(8'h7E);
        repeat (4) begin
            @(negedge clk);
            if (tx_valid || busy) seen_tx++;
        end
        check("bad cmd err pulses", err_cnt - e0, 1);
        check("bad cmd no tx/busy", seen_tx, 0);
        send_frame(1'b0);
        get_resp(17, 0);
        check_resp("after bad cmd", 1'b0);

        // Timeout mid-frame
        e0 = err_cnt;
        send_byte(8'h00);
        send_byte(8'h01);
        send_byte(8'h02);
        cnt = 0;
        while (err !== 1'b1 && cnt < 200) begin
            @(negedge clk);
            cnt++;
        end
        check("timeout cycles", cnt, 100);
        @(negedge clk);
        check("timeout err count", err_cnt - e0, 1);
        check("timeout idle", busy, 1'b0);
        send_frame(1'b0);
        get_resp(17, 0);
        check_resp("after timeout", 1'b0);

        // Back-pressure, plus a stray byte during WAIT
        send_frame(1'b0);
        e0 = err_cnt;
        send_byte(8'h55);
        @(negedge clk);
        check("rx in WAIT err", err_cnt - e0, 1);
        check("rx in WAIT still busy", busy, 1'b1);
        get_resp(17, 50);
        check("stall stability", stall_viol, 0);
        check("stall applied", stalls_used > 0, 1'b1);
        check_resp("stalled", 1'b0);

        // Reset during WAIT
        send_frame(1'b0);
        @(negedge clk);
        @(negedge clk);
        check("in WAIT busy", busy, 1'b1);
        reset = 1'b1;
        #1;
        check_reset_outputs("reset in WAIT");
        @(negedge clk);
        reset = 1'b0;
        send_frame(1'b0);
        get_resp(17, 0);
        check_resp("after WAIT reset", 1'b0);

        // Reset during SEND
        send_frame(1'b0);
        get_resp(5, 0);
        check("partial send busy", busy, 1'b1);
        reset = 1'b1;
        #1;
        check_reset_outputs("reset in SEND");
        @(negedge clk);
        reset = 1'b0;
        send_frame(1'b0);
        get_resp(17, 0);
        check_resp("after SEND reset", 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
